// File: rtl/mux4_sched_pkg.sv
// Shared types and constants for the 4-way round-robin mux scheduler.
package mux4_sched_pkg;

    localparam int unsigned N_REQ = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam sel_t RESET_PTR = 2'd3;

    function automatic logic [N_REQ-1:0] onehot4(input sel_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first set req bit strictly after ptr, wrapping back to ptr last.
module rr_pick4
    import mux4_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             ptr,
    output logic             any,
    output sel_t             winner
);

    logic found;
    sel_t idx;

    always_comb begin
        any    = |req;
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        // Offset 4 wraps to ptr itself, so the previous owner only wins when it is alone.
        for (int i = 1; i <= N_REQ; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler driving the select lines of a shared 4:1 mux with bounded tenure.
// Optional MUX4_RR_SCHED_LOCK_EN adds a lock input that suppresses hold-time expiry.
module mux4_rr_sched
    import mux4_sched_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
`ifdef MUX4_RR_SCHED_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic             s0,
    output logic             s1,
    output logic             valid
);

    localparam logic [CNT_W-1:0] MaxHoldCnt = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sel_t             ptr_q, ptr_d;
    sel_t             sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             valid_q, valid_d;

    sel_t pick_ptr;
    sel_t pick_win;
    logic pick_any;
    logic owner_req;
    logic expired;

    // In GRANT the owner index doubles as the search start for a back-to-back handover.
    assign pick_ptr = (state_q == GRANT) ? sel_q : ptr_q;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .any    (pick_any),
        .winner (pick_win)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
        owner_req = req[sel_q];
        expired   = (cnt_q == MaxHoldCnt);
`ifdef MUX4_RR_SCHED_LOCK_EN
        if (lock && owner_req) begin
            expired = 1'b0;
        end
`endif

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick_win;
                    gnt_d   = onehot4(pick_win);
                    valid_d = 1'b1;
                    cnt_d   = CntOne;
                end
            end
            GRANT: begin
                if (!owner_req || expired) begin
                    ptr_d = sel_q;
                    if (pick_any) begin
                        sel_d   = pick_win;
                        gnt_d   = onehot4(pick_win);
                        valid_d = 1'b1;
                        cnt_d   = CntOne;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != MaxHoldCnt) begin
                    // Saturates at MAX_HOLD while lock holds the tenure open.
                    cnt_d = cnt_q + CntOne;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= RESET_PTR;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign s1    = sel_q[1];
    assign s0    = sel_q[0];
    assign valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed self-checking bench for mux4_rr_sched with MAX_HOLD=4.
// Observed word packs {valid, s1, s0, gnt}; expected words are hand-computed constants.
module tb_mux4_rr_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       valid;
`ifdef MUX4_RR_SCHED_LOCK_EN
    logic       lock;
`endif

    int n_cmp;
    int n_err;

    mux4_rr_sched #(
        .MAX_HOLD (4)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
`ifdef MUX4_RR_SCHED_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .s0    (s0),
        .s1    (s1),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs changed after this take effect at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got {valid,s1,s0,gnt}=%b, need %b", tag, obs, exp_v);
        end
    endtask

    function automatic logic [6:0] obs_word();
        return {valid, s1, s0, gnt};
    endfunction

    logic [6:0] rot_exp [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rot_exp[0] = 7'b1_00_0001;
        rot_exp[1] = 7'b1_01_0010;
        rot_exp[2] = 7'b1_10_0100;
        rot_exp[3] = 7'b1_11_1000;
`ifdef MUX4_RR_SCHED_LOCK_EN
        lock = 1'b0;
`endif
        rst = 1'b1;
        req = 4'b1111;

        // Reset wins over simultaneous requests.
        step();
        step();
        check("reset", obs_word(), 7'b0_00_0000);
        rst = 1'b0;

        // Steady 1111: four cycles per owner, rotating a->b->c->d->a.
        for (int k = 0; k < 17; k++) begin
            step();
            check($sformatf("rot%0d", k), obs_word(), rot_exp[(k / 4) % 4]);
        end

        // Drop everything: a releases, IDLE with select held at 00.
        req = 4'b0000;
        step();
        check("idle_a", obs_word(), 7'b0_00_0000);

        // c alone for two cycles, then release; select stays at 10.
        req = 4'b0100;
        step();
        check("c_t1", obs_word(), 7'b1_10_0100);
        step();
        check("c_t2", obs_word(), 7'b1_10_0100);
        req = 4'b0000;
        step();
        check("c_rel", obs_word(), 7'b0_10_0000);
        step();
        check("idle_hold", obs_word(), 7'b0_10_0000);

        // Pointer at c: search from d wraps to a. Dropping a hands to b on the same edge.
        req = 4'b0011;
        step();
        check("ab_a", obs_word(), 7'b1_00_0001);
        req = 4'b0010;
        step();
        check("ab_b1", obs_word(), 7'b1_01_0010);
        // Counter restarted at 1, so b keeps three more cycles before expiry hands to a.
        req = 4'b0011;
        for (int k = 2; k <= 4; k++) begin
            step();
            check($sformatf("ab_b%0d", k), obs_word(), 7'b1_01_0010);
        end
        step();
        check("ab_to_a", obs_word(), 7'b1_00_0001);

        // a finishes its tenure, b gets three cycles, then reset mid-tenure.
        req = 4'b1111;
        for (int k = 2; k <= 4; k++) begin
            step();
            check($sformatf("r_a%0d", k), obs_word(), 7'b1_00_0001);
        end
        step();
        check("r_b1", obs_word(), 7'b1_01_0010);
        step();
        check("r_b2", obs_word(), 7'b1_01_0010);
        step();
        check("r_b3", obs_word(), 7'b1_01_0010);
        rst = 1'b1;
        step();
        check("mid_rst", obs_word(), 7'b0_00_0000);
        rst = 1'b0;
        step();
        check("post_rst_a", obs_word(), 7'b1_00_0001);

`ifdef MUX4_RR_SCHED_LOCK_EN
        // Lock keeps a beyond MAX_HOLD; releasing lock expires the saturated counter.
        lock = 1'b1;
        for (int k = 2; k <= 10; k++) begin
            step();
            check($sformatf("lock_a%0d", k), obs_word(), 7'b1_00_0001);
        end
        lock = 1'b0;
        step();
        check("unlock_b", obs_word(), 7'b1_01_0010);
`else
        // MAX_HOLD=1-style rotation is not this build; just confirm a still expires at 4.
        for (int k = 2; k <= 4; k++) begin
            step();
            check($sformatf("tail_a%0d", k), obs_word(), 7'b1_00_0001);
        end
        step();
        check("tail_b", obs_word(), 7'b1_01_0010);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
- Round-robin scheduler that shares the 4:1 data mux (inputs a/b/c/d, selects s1/s0) between four requesters.
- Arbitrates the request lines and drives the mux select lines. Issues a one-hot grant to the owning requester.
- Bounds each tenure to a maximum hold time so no requester starves the others.
- Sits directly in front of the mux select inputs. The mux itself stays purely combinational.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one requester owns the mux. Legal range 1..255.
- CNT_W, $clog2(MAX_HOLD+1): width of the hold counter. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per mux input: bit0=a, bit1=b, bit2=c, bit3=d.
- gnt  output 4  one-hot grant; all-zero when idle.
- s0   output 1  mux select LSB.
- s1   output 1  mux select MSB.
- valid output 1  high while some requester owns the mux.

Behaviour:
- Single clock. Reset is synchronous and active-high. All outputs and state are registered.
- Reset values:
  - gnt=0000, s1=0, s0=0, valid=0.
  - State=IDLE, hold counter=0.
  - Last-owner pointer=3, so requester 0 has first priority.
- Select encoding is {s1,s0} = owner index: 00→a, 01→b, 10→c, 11→d.
  - s1/s0 change only on a grant; they hold their last value while IDLE.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from pointer+1 (mod 4).
  - Next edge: gnt=onehot(winner), {s1,s0}=winner, valid=1, counter=1, state→GRANT.
  - Latency from req sampled to gnt is 1 cycle.
  - If req=0000, stay in IDLE.
- GRANT:
  - The owner is released when req[owner]=0 is sampled, or when counter==MAX_HOLD.
  - Without a release: counter increments, and outputs are unchanged.
  - On release: pointer←owner.
    - If any req bit is set, a new winner is searched from owner+1 and granted on the same edge (back-to-back, no idle bubble). counter=1.
    - The owner may win again only if it is the sole requester.
    - If no req bit is set: gnt=0000, valid=0, state→IDLE, s1/s0 hold.
- Non-owner req changes during GRANT have no effect until release.
- MAX_HOLD=1: grant rotates every cycle among the active requesters.
- The counter never exceeds MAX_HOLD and never wraps.
- rst mid-grant: the next edge forces reset values. Any tenure in progress is discarded.
- rst has priority over everything, including simultaneous req.
- gnt is always one-hot or zero. valid equals |gnt.

Optional Feature:
- Macro: MUX4_RR_SCHED_LOCK_EN.
- When defined:
  - Extra input port lock (1 bit).
  - While lock=1 and req[owner]=1, the MAX_HOLD expiry is suppressed and the counter saturates at MAX_HOLD.
  - Dropping req[owner] still releases the owner.
  - Lock is ignored in IDLE.
- When undefined: no lock port; behaviour exactly as above.

Decomposition:
- Shared package mux4_sched_pkg holds:
  - typedef sel_t (2-bit index);
  - enum state_t {IDLE, GRANT};
  - constants N_REQ=4, RESET_PTR=2'd3.
- One natural sub-module, rr_pick4: combinational round-robin search.
  - Inputs: req[3:0], ptr.
  - Outputs: any, winner index.
  - Reused for both the IDLE pick and the back-to-back pick.

Test Plan:
1. rst=1 for 2 cycles with req=1111 → gnt=0000, s1s0=00, valid=0. First edge after rst=0 → gnt=0001, s1s0=00, valid=1.
2. MAX_HOLD=4, req=1111 held steady → gnt=0001 ×4 cycles, 0010 ×4 (s1s0=01), 0100 ×4 (10), 1000 ×4 (11), then 0001 again. valid never drops.
3. req=0100 for 2 cycles then 0000 → gnt=0100 one cycle after req rises and is held 2 cycles. Then gnt=0000, valid=0, s1s0 stays 10.
4. req=0011, req[0] dropped after the 1st grant cycle → next edge gnt=0010, s1s0=01, counter restarts at 1. No idle cycle.
5. req=1111, rst=1 asserted during the 3rd cycle of b's tenure → next edge all outputs at reset values. After rst=0, grant goes to a (0001), not c.
6. With MUX4_RR_SCHED_LOCK_EN, MAX_HOLD=4, req=1111, lock=1 for 10 cycles → gnt=0001 for 10 cycles. Lock→0 → next edge gnt=0010.
